// File: rtl/pb_press_pkg.sv
// Shared definitions for the push-button press classifier: FSM state encoding
// and the default timing constants for a 100 MHz clock.
package pb_press_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_LONG     = 2'd2,
        ST_WAIT_REL = 2'd3
    } pb_state_e;

    // 1 s to qualify a long press, 200 ms auto-repeat period at 100 MHz.
    localparam int unsigned PB_LONG_CYCLES_DEF   = 100_000_000;
    localparam int unsigned PB_REPEAT_CYCLES_DEF = 20_000_000;
    localparam bit          PB_REPEAT_EN_DEF     = 1'b1;

endpackage : pb_press_pkg

// File: rtl/pb_press_fsm.sv
// Classifies a debounced button into short presses, long presses and
// auto-repeat ticks; all outputs are registered single-cycle pulses or levels.
module pb_press_fsm
    import pb_press_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = PB_LONG_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = PB_REPEAT_CYCLES_DEF,
    parameter bit          REPEAT_EN     = PB_REPEAT_EN_DEF
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       pb_debounced,
    output logic       short_press,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       pb_held,
    output logic [7:0] press_count
);

    localparam int HCNT_W = $clog2(LONG_CYCLES);
    localparam int RCNT_W = $clog2(REPEAT_CYCLES + 1);

    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

    pb_state_e         state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              pb_prev_q;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              rep_q, rep_d;
    logic              held_q, held_d;
    logic [7:0]        count_q, count_d;

    logic              press;

    assign press = pb_debounced & ~pb_prev_q;

    // NOTE: every variable gets a default at the top of always_comb so that no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        rcnt_d  = rcnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        count_d = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_PRESSED;
                    hcnt_d  = '0;
                end else if (pb_debounced) begin
                    // Level high without an edge: button was held through reset.
                    state_d = ST_WAIT_REL;
                end
            end

            ST_PRESSED: begin
                // Release is tested first so it wins over reaching the long threshold.
                if (!pb_debounced) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                    count_d = count_q + 8'd1;
                end else if (hcnt_q == HCNT_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    hcnt_d  = hcnt_q + HCNT_W'(1);
                end
            end

            ST_LONG: begin
                if (!pb_debounced) begin
                    state_d = ST_IDLE;
                end else if (REPEAT_EN) begin
                    if (rcnt_q == RCNT_LAST) begin
                        rep_d  = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_W'(1);
                    end
                end
            end

            ST_WAIT_REL: begin
                if (!pb_debounced) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            rcnt_q    <= '0;
            // NOTE: pb_prev resets high so a button held through reset is not
            // mistaken for a fresh press on the first clock after release.
            pb_prev_q <= 1'b1;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            rep_q     <= 1'b0;
            held_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            rcnt_q    <= rcnt_d;
            pb_prev_q <= pb_debounced;
            short_q   <= short_d;
            long_q    <= long_d;
            rep_q     <= rep_d;
            held_q    <= held_d;
            count_q   <= count_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign repeat_pulse = rep_q;
    assign pb_held      = held_q;
    assign press_count  = count_q;

endmodule : pb_press_fsm

// File: tb/tb_pb_press_fsm.sv
// Scoreboard bench for pb_press_fsm with LONG_CYCLES=8, REPEAT_CYCLES=4:
// each press pushes its expected pulses, a negedge monitor pops and compares.
module tb_pb_press_fsm;

    localparam int LC = 8;
    localparam int RC = 4;

    localparam int K_SHORT  = 1;
    localparam int K_LONG   = 2;
    localparam int K_REPEAT = 3;

    typedef struct {
        int         kind;
        int         edge_n;
        logic [7:0] cnt;
    } exp_t;

    logic       clk_100 = 1'b0;
    logic       rst_n;
    logic       pb_debounced;
    logic       short_press;
    logic       long_press;
    logic       repeat_pulse;
    logic       pb_held;
    logic [7:0] press_count;

    int         n_checks = 0;
    int         n_errors = 0;
    int         edge_cnt = 0;
    logic [7:0] exp_cnt;
    exp_t       sb_q[$];

    pb_press_fsm #(
        .LONG_CYCLES  (LC),
        .REPEAT_CYCLES(RC),
        .REPEAT_EN    (1'b1)
    ) dut (
        .clk_100     (clk_100),
        .rst_n       (rst_n),
        .pb_debounced(pb_debounced),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .pb_held     (pb_held),
        .press_count (press_count)
    );

    always #5 clk_100 = ~clk_100;

    // Index of the next rising edge, as seen from a falling edge.
    always @(posedge clk_100) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int kind, input int edge_n, input logic [7:0] cnt);
        exp_t e;
        e.kind   = kind;
        e.edge_n = edge_n;
        e.cnt    = cnt;
        sb_q.push_back(e);
    endtask

    // Called on a falling edge from IDLE: input high for n_high sampled edges,
    // then low for n_low cycles. Expected pulses are derived from the timing rules.
    task automatic do_press(input int n_high, input int n_low);
        int e0;
        pb_debounced = 1'b1;
        e0 = edge_cnt;
        if (n_high <= LC) begin
            exp_cnt = exp_cnt + 8'd1;
            push_exp(K_SHORT, e0 + n_high, exp_cnt);
        end else begin
            push_exp(K_LONG, e0 + LC, exp_cnt);
            for (int k = 1; LC + RC * k <= n_high - 1; k++)
                push_exp(K_REPEAT, e0 + LC + RC * k, exp_cnt);
        end
        @(negedge clk_100);
        check("pb_held_on", pb_held, 1);
        repeat (n_high - 1) @(negedge clk_100);
        pb_debounced = 1'b0;
        repeat (n_low) @(negedge clk_100);
        check("pb_held_off", pb_held, 0);
    endtask

    int         mon_n;
    int         mon_kind;
    exp_t       mon_e;

    always @(negedge clk_100) begin
        if (rst_n === 1'b1) begin
            mon_n = int'(short_press) + int'(long_press) + int'(repeat_pulse);
            if (mon_n != 0) begin
                check("one_pulse_only", mon_n, 1);
                mon_kind = short_press ? K_SHORT : (long_press ? K_LONG : K_REPEAT);
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse_kind", mon_kind, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("pulse_kind", mon_kind, mon_e.kind);
                    check("pulse_edge", edge_cnt - 1, mon_e.edge_n);
                    check("press_count", press_count, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_cnt      = 8'd0;
        pb_debounced = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk_100);
        check("rst_short", short_press, 0);
        check("rst_long", long_press, 0);
        check("rst_repeat", repeat_pulse, 0);
        check("rst_held", pb_held, 0);
        check("rst_count", press_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100);

        // Short press of 3 cycles.
        do_press(3, 2);
        check("short3_count", press_count, 1);
        check("short3_sb_empty", sb_q.size(), 0);

        // Release on the edge where the hold counter reaches LC-1: short wins.
        do_press(LC, 2);
        check("boundary_count", press_count, 2);

        // One cycle past the boundary: long press, no repeat yet.
        do_press(LC + 1, 2);
        // Long hold with two repeats; no short on release.
        do_press(20, 2);
        check("long_count_kept", press_count, 2);
        check("long_sb_empty", sb_q.size(), 0);

        // 256 short presses bring the counter back to its start through a wrap.
        for (int i = 0; i < 256; i++) do_press(1, 1);
        repeat (2) @(negedge clk_100);
        check("wrap_count", press_count, 2);
        check("wrap_sb_empty", sb_q.size(), 0);

        // Button held across reset release: no press until a low then high.
        pb_debounced = 1'b1;
        rst_n        = 1'b0;
        exp_cnt      = 8'd0;
        repeat (2) @(negedge clk_100);
        rst_n = 1'b1;
        repeat (12) @(negedge clk_100);
        check("hold_rst_held", pb_held, 0);
        check("hold_rst_count", press_count, 0);
        pb_debounced = 1'b0;
        repeat (2) @(negedge clk_100);
        do_press(4, 2);
        check("hold_rst_short_count", press_count, 1);

        // Reset asserted while in LONG.
        pb_debounced = 1'b1;
        push_exp(K_LONG, edge_cnt + LC, exp_cnt);
        repeat (LC + 2) @(negedge clk_100);
        check("long_before_rst_held", pb_held, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_held", pb_held, 0);
        check("async_rst_count", press_count, 0);
        check("async_rst_pulses", {short_press, long_press, repeat_pulse}, 0);
        exp_cnt = 8'd0;
        repeat (3) @(negedge clk_100);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_100);
        check("post_rst_held", pb_held, 0);
        pb_debounced = 1'b0;
        repeat (2) @(negedge clk_100);
        do_press(2, 2);

        repeat (5) @(negedge clk_100);
        check("final_sb_empty", sb_q.size(), 0);
        check("final_count", press_count, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pb_press_fsm
